// File: rtl/snes_joy_pkg.sv
// Shared types and constants for the SNES joypad auto-read sequencer.
package snes_joy_pkg;

    localparam int JOY_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        STRB,
        HIGH,
        LOW,
        DONE
    } autojoy_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/joy_clk_pulse.sv
// Single low-pulse timer for a manual serial read: active for HALF_CYC cycles after start.
module joy_clk_pulse #(
    parameter int HALF_CYC = 128
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    output logic active
);

    localparam int W = $clog2(HALF_CYC) + 1;
    localparam logic [W-1:0] LOAD = W'(HALF_CYC - 1);

    logic [W-1:0] cnt;

    // A start while already active is dropped so the pulse is never stretched.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (!active) begin
            if (start) begin
                active <= 1'b1;
                cnt    <= LOAD;
            end
        end else if (cnt == '0) begin
            active <= 1'b0;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/snes_autojoy.sv
// SNES joypad serial sequencer: VBlank auto-read of both ports plus CPU manual strobe/read access.
//  state | meaning
//  IDLE  | no auto-read; manual strobe/read pulses allowed
//  STRB  | joy_strb high for STRB_CYC cycles
//  HIGH  | joy clocks high; last cycle samples both ports
//  LOW   | joy clocks low for HALF_CYC cycles
//  DONE  | publish captured words, pulse done
module snes_autojoy
    import snes_joy_pkg::*;
#(
    parameter int STRB_CYC = 256,
    parameter int HALF_CYC = 128
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                vblank_start,
    input  logic                auto_en,
    input  logic                cpu_strb_wr,
    input  logic                cpu_strb_val,
    input  logic                cpu_rd1,
    input  logic                cpu_rd2,
    output logic                cpu_rd_bit,
    output logic                joy_strb,
    output logic                joy1_clk,
    output logic                joy2_clk,
    input  logic                joy1_di,
    input  logic                joy2_di,
    output logic [JOY_BITS-1:0] joy1_data,
    output logic [JOY_BITS-1:0] joy2_data,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = $clog2(max_int(STRB_CYC, HALF_CYC)) + 1;
    localparam logic [CNT_W-1:0] STRB_LD = CNT_W'(STRB_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF_CYC - 1);

    autojoy_state_t      state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          bit_idx;
    logic [JOY_BITS-1:0] sr1, sr2;
    logic                strb_latch;
    logic                pending;
    logic                p1_active, p2_active;
    logic                manual_busy;
    logic                cnt_tc;

    assign manual_busy = p1_active | p2_active | cpu_rd1 | cpu_rd2;
    assign cnt_tc      = (cnt == '0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!manual_busy && (pending || (vblank_start && auto_en)))
                    state_nxt = STRB;
            end
            STRB: if (cnt_tc) state_nxt = HIGH;
            HIGH: if (cnt_tc) state_nxt = LOW;
            LOW: begin
                if (cnt_tc)
                    state_nxt = (bit_idx == 4'd15) ? DONE : HIGH;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt       <= '0;
            bit_idx   <= '0;
            sr1       <= '0;
            sr2       <= '0;
            joy1_data <= '0;
            joy2_data <= '0;
        end else begin
            if (state_nxt != state)
                cnt <= (state_nxt == STRB) ? STRB_LD : HALF_LD;
            else if (!cnt_tc)
                cnt <= cnt - 1'b1;

            if (state == STRB)
                bit_idx <= '0;
            else if (state == LOW && cnt_tc)
                bit_idx <= bit_idx + 4'd1;

            if (state == HIGH && cnt_tc) begin
                sr1 <= {sr1[JOY_BITS-2:0], ~joy1_di};
                sr2 <= {sr2[JOY_BITS-2:0], ~joy2_di};
            end

            // Both words change together so software never sees a half-updated pair.
            if (state == LOW && state_nxt == DONE) begin
                joy1_data <= sr1;
                joy2_data <= sr2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending    <= 1'b0;
            strb_latch <= 1'b0;
            cpu_rd_bit <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == STRB)
                pending <= 1'b0;
            else if (state == IDLE && vblank_start && auto_en && manual_busy)
                pending <= 1'b1;

            if (cpu_strb_wr)
                strb_latch <= cpu_strb_val;

            if (cpu_rd1)
                cpu_rd_bit <= ~joy1_di;
            else if (cpu_rd2)
                cpu_rd_bit <= ~joy2_di;
        end
    end

    joy_clk_pulse #(.HALF_CYC(HALF_CYC)) u_pulse1 (
        .clk    (clk),
        .resetn (resetn),
        .start  (cpu_rd1 && state == IDLE),
        .active (p1_active)
    );

    joy_clk_pulse #(.HALF_CYC(HALF_CYC)) u_pulse2 (
        .clk    (clk),
        .resetn (resetn),
        .start  (cpu_rd2 && state == IDLE),
        .active (p2_active)
    );

    // DONE still belongs to the sequencer so a latch written mid-read shows only afterwards.
    assign joy_strb = (state != IDLE) ? (state == STRB) : strb_latch;
    assign joy1_clk = ~((state == LOW) | p1_active);
    assign joy2_clk = ~((state == LOW) | p2_active);
    assign busy     = (state == STRB) || (state == HIGH) || (state == LOW);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_snes_autojoy.sv
// Scoreboard bench for snes_autojoy with behavioural pads on both ports.
module tb_snes_autojoy;

    logic        clk = 1'b0;
    logic        resetn, vblank_start, auto_en, cpu_strb_wr, cpu_strb_val, cpu_rd1, cpu_rd2;
    logic        cpu_rd_bit, joy_strb, joy1_clk, joy2_clk, joy1_di, joy2_di, busy, done;
    logic [15:0] joy1_data, joy2_data;

    always #5 clk = ~clk;

    snes_autojoy #(.STRB_CYC(4), .HALF_CYC(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .vblank_start (vblank_start),
        .auto_en      (auto_en),
        .cpu_strb_wr  (cpu_strb_wr),
        .cpu_strb_val (cpu_strb_val),
        .cpu_rd1      (cpu_rd1),
        .cpu_rd2      (cpu_rd2),
        .cpu_rd_bit   (cpu_rd_bit),
        .joy_strb     (joy_strb),
        .joy1_clk     (joy1_clk),
        .joy2_clk     (joy2_clk),
        .joy1_di      (joy1_di),
        .joy2_di      (joy2_di),
        .joy1_data    (joy1_data),
        .joy2_data    (joy2_data),
        .busy         (busy),
        .done         (done)
    );

    // Pads: reload while strobed, shift on a falling serial clock, fill with released buttons.
    logic [15:0] pat1 = '0, pat2 = '0, pad1 = '0, pad2 = '0;
    logic        prev1 = 1'b1, prev2 = 1'b1;
    always @(posedge clk) begin
        prev1 <= joy1_clk;
        prev2 <= joy2_clk;
        if (joy_strb) begin
            pad1 <= pat1;
            pad2 <= pat2;
        end else begin
            if (prev1 && !joy1_clk) pad1 <= {pad1[14:0], 1'b0};
            if (prev2 && !joy2_clk) pad2 <= {pad2[14:0], 1'b0};
        end
    end
    assign joy1_di = ~pad1[15];
    assign joy2_di = ~pad2[15];

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] done_q[$];
    logic        rd_q[$];
    logic [31:0] exp_w;
    logic        exp_b;
    logic        rd_taken = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) rd_taken <= resetn && (cpu_rd1 || cpu_rd2);

    always @(negedge clk) begin
        if (resetn && done) begin
            if (done_q.size() == 0) begin
                n_checks++;
                $display("FAIL done_unexpected: got done=1 expected no update");
            end else begin
                exp_w = done_q.pop_front();
                check("joy1_data", {16'h0, joy1_data}, {16'h0, exp_w[31:16]});
                check("joy2_data", {16'h0, joy2_data}, {16'h0, exp_w[15:0]});
                check("busy_at_done", {31'h0, busy}, 32'h0);
            end
        end
        if (rd_taken) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got a read with no expectation");
            end else begin
                exp_b = rd_q.pop_front();
                check("cpu_rd_bit", {31'h0, cpu_rd_bit}, {31'h0, exp_b});
            end
        end
    end

    task automatic clear_pulses();
        vblank_start = 1'b0;
        cpu_rd1      = 1'b0;
        cpu_rd2      = 1'b0;
        cpu_strb_wr  = 1'b0;
    endtask

    // mode 1 plain, 2 second vblank mid-read, 4 deferred by cpu_rd2, 5 manual access while busy, 6 reset in bit 7
    task automatic run_read(input int mode, input logic [15:0] e1, input logic [15:0] e2,
                            input logic [15:0] o1, input logic [15:0] o2,
                            output int first_busy, output int done_at, output int busy_n,
                            output int strb_n, output int f1, output int f2, output int held_bad);
        logic pc1, pc2;
        first_busy = -1; done_at = -1; busy_n = 0; strb_n = 0; f1 = 0; f2 = 0; held_bad = 0;
        @(negedge clk);
        if (mode != 6) done_q.push_back({e1, e2});
        if (mode == 4) begin
            cpu_rd2 = 1'b1;
            rd_q.push_back(1'b0);
            @(negedge clk);
            clear_pulses();
        end
        vblank_start = 1'b1;
        auto_en      = 1'b1;
        pc1 = joy1_clk;
        pc2 = joy2_clk;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            clear_pulses();
            if (mode == 6 && i == 34) begin
                check("rst_strb", {31'h0, joy_strb}, 32'h0);
                check("rst_clks", {30'h0, joy1_clk, joy2_clk}, 32'h3);
                check("rst_data", {joy1_data, joy2_data}, 32'h0);
                check("rst_busy_done", {30'h0, busy, done}, 32'h0);
                check("rst_rd_bit", {31'h0, cpu_rd_bit}, 32'h0);
                resetn = 1'b1;
                break;
            end
            if (busy && first_busy < 0) first_busy = i;
            if (busy) busy_n++;
            if ((busy || done) && joy_strb) strb_n++;
            if (pc1 && !joy1_clk) f1++;
            if (pc2 && !joy2_clk) f2++;
            pc1 = joy1_clk;
            pc2 = joy2_clk;
            if (!done && (joy1_data !== o1 || joy2_data !== o2)) held_bad++;
            if (done) begin
                done_at = i;
                break;
            end
            if (mode == 2 && i == 20) vblank_start = 1'b1;
            if (mode == 5 && i == 2) begin
                cpu_rd1      = 1'b1;
                cpu_strb_wr  = 1'b1;
                cpu_strb_val = 1'b1;
                rd_q.push_back(1'b1);
            end
            if (mode == 6 && i == 33) resetn = 1'b0;
        end
        if (mode != 6 && done_at < 0) begin
            n_checks++;
            $display("FAIL done_timeout: got no done in 300 cycles expected done");
        end
    endtask

    initial begin
        int fb, da, bn, sn, f1, f2, hb, cnt_a, cnt_b;
        resetn = 1'b0; auto_en = 1'b0; cpu_strb_val = 1'b0;
        clear_pulses();
        repeat (3) @(negedge clk);
        check("reset_outs", {25'h0, joy_strb, joy1_clk, joy2_clk, busy, done, cpu_rd_bit, 1'b0},
              {25'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_data", {joy1_data, joy2_data}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: plain auto-read
        pat1 = 16'h8000; pat2 = 16'h0F00;
        run_read(1, 16'h8000, 16'h0F00, 16'h0, 16'h0, fb, da, bn, sn, f1, f2, hb);
        check("t1_first_busy", fb, 1);
        check("t1_done_at", da, 69);
        check("t1_busy_cycles", bn, 68);
        check("t1_strb_cycles", sn, 4);
        check("t1_pulses", {f1[15:0], f2[15:0]}, {16'd16, 16'd16});
        check("t1_held", hb, 0);

        // 2: second vblank mid-read is ignored
        pat1 = 16'h1234; pat2 = 16'h00FF;
        run_read(2, 16'h1234, 16'h00FF, 16'h8000, 16'h0F00, fb, da, bn, sn, f1, f2, hb);
        check("t2_done_at", da, 69);
        check("t2_pulses", {f1[15:0], f2[15:0]}, {16'd16, 16'd16});
        check("t2_held", hb, 0);
        cnt_a = 0;
        repeat (12) begin @(negedge clk); if (busy) cnt_a++; end
        check("t2_no_rerun", cnt_a, 0);

        // 3: auto disabled, manual strobe and 16 manual reads
        pat1 = 16'hA5C3; pat2 = 16'h7000;
        auto_en = 1'b0; vblank_start = 1'b1;
        cnt_a = 0;
        repeat (12) begin @(negedge clk); clear_pulses(); if (busy || joy_strb) cnt_a++; end
        check("t3_no_auto", cnt_a, 0);
        cpu_strb_wr = 1'b1; cpu_strb_val = 1'b1;
        @(negedge clk); clear_pulses();
        check("t3_strb_hi", {31'h0, joy_strb}, 32'h1);
        cpu_strb_wr = 1'b1; cpu_strb_val = 1'b0;
        @(negedge clk); clear_pulses();
        check("t3_strb_lo", {31'h0, joy_strb}, 32'h0);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 16; k++) begin
            cpu_rd1 = 1'b1;
            rd_q.push_back(pat1[15-k]);
            repeat (4) begin
                logic q1, q2;
                q1 = joy1_clk; q2 = joy2_clk;
                @(negedge clk); clear_pulses();
                if (q1 && !joy1_clk) cnt_a++;
                if (q2 && !joy2_clk) cnt_b++;
            end
        end
        check("t3_joy1_pulses", cnt_a, 16);
        check("t3_joy2_pulses", cnt_b, 0);

        // 4: auto-read deferred behind a manual port-2 pulse
        run_read(4, 16'hA5C3, 16'h7000, 16'h1234, 16'h00FF, fb, da, bn, sn, f1, f2, hb);
        check("t4_first_busy", fb, 3);
        check("t4_done_at", da, 71);
        check("t4_pulses", {f1[15:0], f2[15:0]}, {16'd16, 16'd16});

        // 5: manual read and strobe write while busy
        pat1 = 16'hC001; pat2 = 16'h0180;
        run_read(5, 16'hC001, 16'h0180, 16'hA5C3, 16'h7000, fb, da, bn, sn, f1, f2, hb);
        check("t5_done_at", da, 69);
        check("t5_pulses", {f1[15:0], f2[15:0]}, {16'd16, 16'd16});
        check("t5_strb_in_read", sn, 4);
        check("t5_strb_at_done", {31'h0, joy_strb}, 32'h0);
        @(negedge clk);
        check("t5_strb_after", {31'h0, joy_strb}, 32'h1);
        cpu_strb_wr = 1'b1; cpu_strb_val = 1'b0;
        @(negedge clk); clear_pulses();
        @(negedge clk);

        // 6: reset during bit 7, then a clean read
        run_read(6, 16'h0, 16'h0, 16'hC001, 16'h0180, fb, da, bn, sn, f1, f2, hb);
        check("t6_held_before_rst", hb, 0);
        @(negedge clk);
        pat1 = 16'h5A5A; pat2 = 16'hF00F;
        run_read(1, 16'h5A5A, 16'hF00F, 16'h0, 16'h0, fb, da, bn, sn, f1, f2, hb);
        check("t6_done_at", da, 69);
        check("t6_busy_cycles", bn, 68);

        repeat (3) @(negedge clk);
        check("done_q_drained", done_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
